// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl: start/stop/clear sequencer with prescaler and terminal count for a shared gray_code_counter
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   cmd_valid_i/ready_o  command handshake; cmd_op_i 00 NOP, 01 START, 10 STOP, 11 CLEAR
//   cfg_limit_i          terminal binary count, sampled on START from IDLE
//   cfg_prescale_i       tick period minus one, sampled with cfg_limit_i
//   cfg_reload_i         1 auto-reload, 0 one-shot, sampled with cfg_limit_i
//   cnt_binary_i         binary feedback from the counter
//   cnt_rst_o, cnt_ce_o  counter reset and count enable
//   busy_o               high in ARM, RUN and PAUSED
//   done_o               one-cycle pulse after each terminal tick
//   reload_cnt_o         saturating count of auto-reloads
module gray_counter_ctrl #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [WIDTH-1:0]          cfg_limit_i,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale_i,
    input  logic                      cfg_reload_i,
    input  logic [WIDTH-1:0]          cnt_binary_i,
    output logic                      cnt_rst_o,
    output logic                      cnt_ce_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [7:0]                reload_cnt_o
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, PAUSED} state_t;
    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] p;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [WIDTH-1:0]          limit_q;
    logic                      reload_q;
    logic                      accept;
    logic                      start_acc;
    logic                      stop_acc;
    logic                      clear_acc;
    logic                      tick;
    logic                      terminal;
    always_comb begin
        cmd_ready_o = !rst_i && state != ARM;
        accept      = cmd_valid_i && cmd_ready_o;
        start_acc   = accept && cmd_op_i == 2'b01;
        stop_acc    = accept && cmd_op_i == 2'b10;
        clear_acc   = accept && cmd_op_i == 2'b11;
        // an accepted STOP or CLEAR swallows a coincident tick entirely
        tick        = state == RUN && p == prescale_q && !stop_acc && !clear_acc;
        terminal    = cnt_binary_i == limit_q;
        cnt_ce_o    = !rst_i && tick && !terminal;
        cnt_rst_o   = rst_i || state == ARM || (tick && terminal && reload_q) || clear_acc;
        busy_o      = state != IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            p            <= '0;
            prescale_q   <= '0;
            limit_q      <= '0;
            reload_q     <= 1'b0;
            done_o       <= 1'b0;
            reload_cnt_o <= '0;
        end else begin
            done_o <= tick && terminal;
            if (clear_acc) begin
                state        <= IDLE;
                p            <= '0;
                reload_cnt_o <= '0;
            end else begin
                case (state)
                    IDLE: if (start_acc) begin
                        limit_q      <= cfg_limit_i;
                        prescale_q   <= cfg_prescale_i;
                        reload_q     <= cfg_reload_i;
                        reload_cnt_o <= '0;
                        state        <= ARM;
                    end
                    ARM: begin
                        p     <= '0;
                        state <= RUN;
                    end
                    RUN: if (stop_acc) begin
                        // p is frozen so resuming continues the same prescale phase
                        state <= PAUSED;
                    end else begin
                        p <= tick ? '0 : p + 1'b1;
                        if (tick && terminal) begin
                            if (reload_q)
                                reload_cnt_o <= (reload_cnt_o == 8'hFF) ? reload_cnt_o : reload_cnt_o + 8'd1;
                            else
                                state <= IDLE;
                        end
                    end
                    PAUSED: if (start_acc) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
